// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider configuration sequencer.
package clk_div_pkg;

  typedef enum logic [1:0] {
    APPLY,
    RUN,
    WAIT_EDGE
  } state_t;

  localparam int unsigned CNT_W = 32;

  // Divide value used at reset; also used by the divider's top-level instantiation.
  localparam logic [CNT_W-1:0] DEFAULT_MAX = 32'd49_999_999;

endpackage

// File: rtl/clk_div_ctrl.sv
// Configuration sequencer for the programmable clock divider: accepts divide
// values, pulses the divider reset and optionally defers retune to an output edge.
module clk_div_ctrl #(
  parameter logic [31:0] DEFAULT_MAX  = clk_div_pkg::DEFAULT_MAX,
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] WAIT_LIMIT   = 32'd100_000_000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_max,
  input  logic        cfg_sync,
  input  logic        div_clk_out,
  output logic        div_reset,
  output logic [31:0] div_counter_max,
  output logic        busy,
  output logic        locked,
  output logic        timeout
);

  import clk_div_pkg::*;

  state_t           state;
  logic [31:0]      apply_cnt;
  logic [CNT_W-1:0] pending;
  logic [31:0]      wait_cnt;
  logic             prev_clk;
  logic             first_run;

  logic clk_edge;
  logic qual_edge;
  logic xfer;

  assign clk_edge = div_clk_out ^ prev_clk;
  // The first RUN cycle still sees the divider's reset-induced clear, so ignore it.
  assign qual_edge = clk_edge &&
                     (((state == RUN) && !first_run) || (state == WAIT_EDGE));
  assign xfer = cfg_valid && cfg_ready;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state           <= APPLY;
      apply_cnt       <= '0;
      pending         <= '0;
      wait_cnt        <= '0;
      prev_clk        <= 1'b0;
      first_run       <= 1'b0;
      div_counter_max <= DEFAULT_MAX;
      div_reset       <= 1'b1;
      cfg_ready       <= 1'b0;
      busy            <= 1'b1;
      locked          <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      prev_clk <= div_clk_out;
      timeout  <= 1'b0;

      case (state)
        APPLY: begin
          locked <= 1'b0;
          if (apply_cnt == 32'(RESET_CYCLES - 1)) begin
            apply_cnt <= '0;
            state     <= RUN;
            first_run <= 1'b1;
            div_reset <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            apply_cnt <= apply_cnt + 32'd1;
          end
        end

        RUN: begin
          first_run <= 1'b0;
          if (qual_edge) begin
            locked <= 1'b1;
          end
          if (xfer && (cfg_max != div_counter_max)) begin
            if (!cfg_sync || !locked) begin
              div_counter_max <= cfg_max;
              state           <= APPLY;
              apply_cnt       <= '0;
              div_reset       <= 1'b1;
              cfg_ready       <= 1'b0;
              busy            <= 1'b1;
              locked          <= 1'b0;
            end else begin
              pending   <= cfg_max;
              wait_cnt  <= '0;
              state     <= WAIT_EDGE;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end

        WAIT_EDGE: begin
          // An edge on the limit cycle wins, so timeout only fires with no edge.
          if (qual_edge || (wait_cnt == WAIT_LIMIT - 32'd1)) begin
            timeout         <= !qual_edge;
            div_counter_max <= pending;
            state           <= APPLY;
            apply_cnt       <= '0;
            div_reset       <= 1'b1;
            cfg_ready       <= 1'b0;
            busy            <= 1'b1;
            locked          <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        default: begin
          state     <= APPLY;
          apply_cnt <= '0;
          div_reset <= 1'b1;
          cfg_ready <= 1'b0;
          busy      <= 1'b1;
          locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule
